axi_sram_slv: RTL and testbench
===============================

// Module: axi_sram_slv
// PURPOSE
//  - AXI4-Lite slave memory sitting directly downstream of the IFU/LSU AXI arbiter.
//  - Terminates the arbiter's mst_* AR/R/AW/W/B channels.
//  - Models on-chip SRAM with LFSR-driven random response latency, exercising the
//    arbiter's RD_REQ/RD_RSP waits and the LSU write path.
//  - Independent read and write engines. One outstanding transaction per direction.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of word 0
//  MEM_WORDS  32768          depth in data-bus words (128 KiB at 32-bit data)
//  MEM_INIT   ""             $readmemh image file; "" = leave uninitialised
//  RAND_DLY   1              1: delay = lfsr[3:0]; 0: delay = FIX_DLY
//  FIX_DLY    4'd0           fixed extra wait cycles (0..15) when RAND_DLY = 0
//  LFSR_SEED  8'hA5          LFSR reset value; must be non-zero
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           asynchronous reset, active-high
//  slv_ar_valid_i/ar_addr_i/ar_ready_o   in/in/out   1/addr_bus/1   read address
//  slv_r_valid_o/r_data_o/r_resp_o/r_ready_i   out/out/out/in   1/data_bus/axi_resp_t/1   read data
//  slv_aw_valid_i/aw_addr_i/aw_ready_o   in/in/out   1/addr_bus/1   write address
//  slv_w_valid_i/w_data_i/w_strb_i/w_ready_o   in/in/in/out   1/data_bus/strb_bus/1   write data
//  slv_b_valid_o/b_resp_o/b_ready_i   out/out/in   1/axi_resp_t/1   write response
// BEHAVIOUR
//  Reset (async, rst_i = 1):
//   - Read and write FSMs go to IDLE; lfsr = LFSR_SEED.
//   - Outputs during and after reset: r_valid = 0, b_valid = 0, r_data = 0, r_resp = OKAY;
//     ar_ready, aw_ready, w_ready = 1 after reset (IDLE).
//   - Reset mid-transaction drops the transaction. Memory contents are not cleared.
//  LFSR:
//   - 8-bit Galois, poly x^8+x^6+x^5+x^4+1, advances every cycle.
//   - Each engine samples lfsr[3:0] at its accepting handshake.
//  Address decode:
//   - idx = (addr - BASE_ADDR) >> log2(data bytes); low address bits are ignored.
//   - In range means BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*bytes.
//   - Out of range gives resp DECERR (2'b11): read data 0, write suppressed.
//  Read FSM R_IDLE -> R_WAIT -> R_RSP:
//   - R_IDLE: ar_ready = 1. AR handshake latches addr and delay cnt, then goes to R_WAIT.
//   - R_WAIT: cnt == 0 reads mem[idx] into the r_data register and goes to R_RSP; else cnt--.
//   - R_RSP: r_valid = 1. r_data/r_resp held stable until the R handshake, then R_IDLE.
//   - Latency: AR handshake in cycle t gives r_valid first high in cycle t+2+delay.
//   - Back-to-back: a new AR is accepted no earlier than the cycle after the R handshake.
//  Write FSM W_IDLE -> W_WAIT -> W_RSP:
//   - W_IDLE: aw_ready = !aw_got, w_ready = !w_got. AW and W are accepted in either
//     order or in the same cycle, each latched once.
//   - When both are latched, go to W_WAIT with the delay sampled that cycle.
//   - W_WAIT: cnt == 0 commits the strobed byte lanes of mem[idx] (w_strb bit i writes
//     byte i) and goes to W_RSP; else cnt--.
//   - W_RSP: b_valid = 1 with b_resp held until the B handshake, then W_IDLE with both
//     got flags cleared.
//   - w_strb = 0 commits nothing and returns OKAY.
//  Read/write ordering:
//   - A read sampling in the same cycle as a write commit to the same word returns the
//     OLD data.
//   - A read sampling after the commit returns the new data.
//  Valid/ready rules:
//   - r_valid/b_valid never depend combinationally on r_ready/b_ready.
//   - ready outputs are decoded from registered state only, so there is no comb path
//     in -> out.
//  SLVERR is never generated.
// STRUCTURE
//  - Shared package holds: axi_resp_t (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10,
//    DECERR 2'b11), the read FSM state enum, the write FSM state enum, and the
//    AXI bus-width macros.
//  - Sub-module axi_lfsr8 (params SEED; ports clk_i, rst_i, q_o[7:0]) is reusable by
//    other delay models.
//  - Memory is an inferred reg array with per-byte write enables.
// TESTING
//  1. Reset release:
//     - Check ar_ready = aw_ready = w_ready = 1, r_valid = b_valid = 0.
//     - Assert rst_i mid-R_WAIT: r_valid stays 0; next AR is accepted.
//  2. RAND_DLY = 0, FIX_DLY = 0:
//     - Write 32'hDEAD_BEEF to 8000_0010 with strb 4'hF -> b_resp OKAY.
//     - Read 8000_0010 -> r_valid 2 cycles after AR handshake, data DEAD_BEEF, OKAY.
//  3. Partial strobe:
//     - Write 32'h1122_3344 with strb 4'b0101 over DEAD_BEEF -> read returns DE22_BE44.
//  4. Out of range:
//     - AR 8002_0000 (MEM_WORDS = 32768) -> r_data 0, r_resp DECERR.
//     - AW 7FFF_FFFC -> b_resp DECERR and memory unchanged.
//  5. Handshake ordering and backpressure:
//     - W before AW (3-cycle gap) and AW+W in the same cycle both complete with one B each.
//     - Hold r_ready = 0 for 5 cycles -> r_data/r_resp stable, no new AR accepted.
//  6. RAND_DLY = 1, 1000 random R/W to 64 words vs scoreboard:
//     - Data matches; latency = 2 + sampled lfsr[3:0].
//     - Same-cycle read-sample and write-commit returns old data.

Source files
------------

// File: rtl/axi_sram_slv_pkg.sv
// Shared types for the AXI4-Lite SRAM slave: bus widths, response codes and FSM states.
package axi_sram_slv_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [AXI_ADDR_W-1:0] addr_bus_t;
  typedef logic [AXI_DATA_W-1:0] data_bus_t;
  typedef logic [AXI_STRB_W-1:0] strb_bus_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RSP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RSP
  } wr_state_e;

endpackage

// File: rtl/axi_lfsr8.sv
// Free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) used as a random delay source.
module axi_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Right-shifting Galois form: the taps x^8,x^6,x^5,x^4 fold into mask 8'hB8.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/axi_sram_slv.sv
// AXI4-Lite SRAM slave with independent read/write engines and LFSR-driven response latency.
module axi_sram_slv
  import axi_sram_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 32768,
  parameter string       MEM_INIT  = "",
  parameter bit          RAND_DLY  = 1'b1,
  parameter logic [3:0]  FIX_DLY   = 4'd0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      slv_ar_valid_i,
  input  addr_bus_t slv_ar_addr_i,
  output logic      slv_ar_ready_o,
  output logic      slv_r_valid_o,
  output data_bus_t slv_r_data_o,
  output axi_resp_t slv_r_resp_o,
  input  logic      slv_r_ready_i,
  input  logic      slv_aw_valid_i,
  input  addr_bus_t slv_aw_addr_i,
  output logic      slv_aw_ready_o,
  input  logic      slv_w_valid_i,
  input  data_bus_t slv_w_data_i,
  input  strb_bus_t slv_w_strb_i,
  output logic      slv_w_ready_o,
  output logic      slv_b_valid_o,
  output axi_resp_t slv_b_resp_o,
  input  logic      slv_b_ready_i
);

  localparam int        BYTE_SH   = $clog2(AXI_STRB_W);
  localparam int        IDX_W     = $clog2(MEM_WORDS);
  localparam addr_bus_t MEM_BYTES = addr_bus_t'(MEM_WORDS * AXI_STRB_W);

  // Unsigned wrap makes addresses below BASE_ADDR land far above MEM_BYTES.
  function automatic logic addr_hit(input addr_bus_t a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input addr_bus_t a);
    return IDX_W'((a - BASE_ADDR) >> BYTE_SH);
  endfunction

  data_bus_t mem_q [MEM_WORDS];

  logic [7:0] lfsr;
  logic [3:0] dly;
  logic       unused_lfsr_hi;

  axi_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .q_o   (lfsr)
  );

  assign dly            = RAND_DLY ? lfsr[3:0] : FIX_DLY;
  assign unused_lfsr_hi = ^lfsr[7:4];

  rd_state_e        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             rd_err_q, rd_err_d;
  logic [3:0]       rd_cnt_q, rd_cnt_d;
  data_bus_t        r_data_q, r_data_d;
  axi_resp_t        r_resp_q, r_resp_d;

  wr_state_e        wr_state_q, wr_state_d;
  logic             aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_err_q, wr_err_d;
  data_bus_t        wr_data_q, wr_data_d;
  strb_bus_t        wr_strb_q, wr_strb_d;
  logic [3:0]       wr_cnt_q, wr_cnt_d;
  axi_resp_t        b_resp_q, b_resp_d;
  logic             wr_commit;
  logic             aw_hs, w_hs;

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_idx_d       = rd_idx_q;
    rd_err_d       = rd_err_q;
    rd_cnt_d       = rd_cnt_q;
    r_data_d       = r_data_q;
    r_resp_d       = r_resp_q;
    slv_ar_ready_o = 1'b0;
    slv_r_valid_o  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        slv_ar_ready_o = 1'b1;
        if (slv_ar_valid_i) begin
          rd_idx_d   = addr_idx(slv_ar_addr_i);
          rd_err_d   = !addr_hit(slv_ar_addr_i);
          rd_cnt_d   = dly;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          r_data_d   = rd_err_q ? '0 : mem_q[rd_idx_q];
          r_resp_d   = rd_err_q ? DECERR : OKAY;
          rd_state_d = R_RSP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      R_RSP: begin
        slv_r_valid_o = 1'b1;
        if (slv_r_ready_i) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // AW and W are captured independently; the engine leaves IDLE once both are held.
  always_comb begin
    wr_state_d     = wr_state_q;
    aw_got_d       = aw_got_q;
    w_got_d        = w_got_q;
    wr_idx_d       = wr_idx_q;
    wr_err_d       = wr_err_q;
    wr_data_d      = wr_data_q;
    wr_strb_d      = wr_strb_q;
    wr_cnt_d       = wr_cnt_q;
    b_resp_d       = b_resp_q;
    slv_aw_ready_o = 1'b0;
    slv_w_ready_o  = 1'b0;
    slv_b_valid_o  = 1'b0;
    wr_commit      = 1'b0;
    aw_hs          = (wr_state_q == W_IDLE) && !aw_got_q && slv_aw_valid_i;
    w_hs           = (wr_state_q == W_IDLE) && !w_got_q && slv_w_valid_i;
    case (wr_state_q)
      W_IDLE: begin
        slv_aw_ready_o = !aw_got_q;
        slv_w_ready_o  = !w_got_q;
        if (aw_hs) begin
          wr_idx_d = addr_idx(slv_aw_addr_i);
          wr_err_d = !addr_hit(slv_aw_addr_i);
          aw_got_d = 1'b1;
        end
        if (w_hs) begin
          wr_data_d = slv_w_data_i;
          wr_strb_d = slv_w_strb_i;
          w_got_d   = 1'b1;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_cnt_d   = dly;
          wr_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          wr_commit  = !wr_err_q;
          b_resp_d   = wr_err_q ? DECERR : OKAY;
          wr_state_d = W_RSP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      W_RSP: begin
        slv_b_valid_o = 1'b1;
        if (slv_b_ready_i) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= '0;
      rd_err_q   <= 1'b0;
      rd_cnt_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_err_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_cnt_q   <= '0;
      b_resp_q   <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_err_q   <= rd_err_d;
      rd_cnt_q   <= rd_cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_idx_q   <= wr_idx_d;
      wr_err_q   <= wr_err_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_cnt_q   <= wr_cnt_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // No reset on the array; a read sampling in the commit cycle still sees the old word.
  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      for (int i = 0; i < AXI_STRB_W; i++) begin
        if (wr_strb_q[i]) mem_q[wr_idx_q][8*i +: 8] <= wr_data_q[8*i +: 8];
      end
    end
  end

  assign slv_r_data_o = r_data_q;
  assign slv_r_resp_o = r_resp_q;
  assign slv_b_resp_o = b_resp_q;

endmodule

// File: tb/tb_axi_sram_slv.sv
// Directed and scoreboarded checks of axi_sram_slv: a fixed-latency and a random-latency instance.
module tb_axi_sram_slv;
  import axi_sram_slv_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arValid [2];
  logic [31:0] arAddr  [2];
  logic        arReady [2];
  logic        rValid  [2];
  logic [31:0] rData   [2];
  axi_resp_t   rResp   [2];
  logic        rReady  [2];
  logic        awValid [2];
  logic [31:0] awAddr  [2];
  logic        awReady [2];
  logic        wValid  [2];
  logic [31:0] wData   [2];
  logic [3:0]  wStrb   [2];
  logic        wReady  [2];
  logic        bValid  [2];
  axi_resp_t   bResp   [2];
  logic        bReady  [2];

  int compared   = 0;
  int mismatched = 0;

  axi_sram_slv #(.RAND_DLY(1'b0), .FIX_DLY(4'd0)) dutFix (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(arValid[0]), .slv_ar_addr_i(arAddr[0]), .slv_ar_ready_o(arReady[0]),
    .slv_r_valid_o(rValid[0]), .slv_r_data_o(rData[0]), .slv_r_resp_o(rResp[0]),
    .slv_r_ready_i(rReady[0]),
    .slv_aw_valid_i(awValid[0]), .slv_aw_addr_i(awAddr[0]), .slv_aw_ready_o(awReady[0]),
    .slv_w_valid_i(wValid[0]), .slv_w_data_i(wData[0]), .slv_w_strb_i(wStrb[0]),
    .slv_w_ready_o(wReady[0]),
    .slv_b_valid_o(bValid[0]), .slv_b_resp_o(bResp[0]), .slv_b_ready_i(bReady[0])
  );

  axi_sram_slv #(.RAND_DLY(1'b1)) dutRnd (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(arValid[1]), .slv_ar_addr_i(arAddr[1]), .slv_ar_ready_o(arReady[1]),
    .slv_r_valid_o(rValid[1]), .slv_r_data_o(rData[1]), .slv_r_resp_o(rResp[1]),
    .slv_r_ready_i(rReady[1]),
    .slv_aw_valid_i(awValid[1]), .slv_aw_addr_i(awAddr[1]), .slv_aw_ready_o(awReady[1]),
    .slv_w_valid_i(wValid[1]), .slv_w_data_i(wData[1]), .slv_w_strb_i(wStrb[1]),
    .slv_w_ready_o(wReady[1]),
    .slv_b_valid_o(bValid[1]), .slv_b_resp_o(bResp[1]), .slv_b_ready_i(bReady[1])
  );

  // Reference LFSR: Galois x^8+x^6+x^5+x^4+1, seed A5, steps every clock out of reset.
  logic [7:0] lfsrModel;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsrModel <= 8'hA5;
    else     lfsrModel <= lfsrModel[0] ? ((lfsrModel >> 1) ^ 8'hB8) : (lfsrModel >> 1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the R handshake.
  task automatic axiRead(input int d, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output axi_resp_t resp,
                         output int lat, output logic [3:0] dly);
    logic hs;
    int   n;
    data = '0; resp = OKAY; lat = -1; dly = '0;
    arAddr[d] = addr; arValid[d] = 1'b1; n = 0;
    do begin
      hs  = arReady[d];
      dly = lfsrModel[3:0];
      @(negedge clk);
      n++;
    end while (!hs && n < 50);
    arValid[d] = 1'b0;
    if (!hs) begin
      checkOutput("ar handshake timeout", 64'd0, 64'd1);
      return;
    end
    lat = 1;
    while (!rValid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rValid[d]) begin
      checkOutput("r_valid timeout", 64'd0, 64'd1);
      return;
    end
    data = rData[d];
    resp = rResp[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("r hold valid", rValid[d], 1);
      checkOutput("r hold data", rData[d], data);
      checkOutput("r hold resp", rResp[d], resp);
      checkOutput("ar_ready during r stall", arReady[d], 0);
    end
    rReady[d] = 1'b1;
    @(negedge clk);
    rReady[d] = 1'b0;
  endtask

  // AW goes valid awAt cycles and W wAt cycles after the call; returns after the B handshake.
  task automatic axiWrite(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awAt, input int wAt,
                          output axi_resp_t resp);
    logic awDone, wDone, awHs, wHs;
    int   c, n;
    resp = OKAY;
    awAddr[d] = addr; wData[d] = data; wStrb[d] = strb;
    awDone = 1'b0; wDone = 1'b0; c = 0;
    while (!(awDone && wDone) && c < 60) begin
      if (wDone && !awDone)  checkOutput("w_ready after W latched", wReady[d], 0);
      if (awDone && !wDone)  checkOutput("aw_ready after AW latched", awReady[d], 0);
      awValid[d] = !awDone && (c >= awAt);
      wValid[d]  = !wDone && (c >= wAt);
      awHs = awValid[d] && awReady[d];
      wHs  = wValid[d] && wReady[d];
      @(negedge clk);
      c++;
      if (awHs) awDone = 1'b1;
      if (wHs)  wDone  = 1'b1;
    end
    awValid[d] = 1'b0;
    wValid[d]  = 1'b0;
    if (!(awDone && wDone)) begin
      checkOutput("aw/w handshake timeout", 64'd0, 64'd1);
      return;
    end
    n = 0;
    while (!bValid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bValid[d]) begin
      checkOutput("b_valid timeout", 64'd0, 64'd1);
      return;
    end
    resp = bResp[d];
    bReady[d] = 1'b1;
    @(negedge clk);
    bReady[d] = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [31:0] rd, rdOld, v;
    logic [31:0] sb [64];
    axi_resp_t   rr, br, brX;
    int          lat, latX, idx;
    logic [3:0]  dl, dlX, s;

    // Reset values, then release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("r_valid in reset", rValid[d], 0);
      checkOutput("b_valid in reset", bValid[d], 0);
      checkOutput("r_data in reset", rData[d], 0);
      checkOutput("r_resp in reset", rResp[d], OKAY);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("ar_ready after reset", arReady[d], 1);
      checkOutput("aw_ready after reset", awReady[d], 1);
      checkOutput("w_ready after reset", wReady[d], 1);
      checkOutput("r_valid after reset", rValid[d], 0);
      checkOutput("b_valid after reset", bValid[d], 0);
    end

    // Reset during R_WAIT drops the read but keeps memory.
    axiWrite(1, BASE, 32'h5A5A_0001, 4'hF, 0, 0, br);
    checkOutput("pre-reset write bresp", br, OKAY);
    arAddr[1] = BASE; arValid[1] = 1'b1;
    checkOutput("ar_ready before reset read", arReady[1], 1);
    @(negedge clk);
    arValid[1] = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("ar_ready in mid-read reset", arReady[1], 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("r_valid in mid-read reset", rValid[1], 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("r_valid after mid-read reset", rValid[1], 0);
    end
    axiRead(1, BASE, 0, rd, rr, lat, dl);
    checkOutput("read after reset data", rd, 32'h5A5A_0001);
    checkOutput("read after reset latency", lat, 2 + int'(dl));

    // Fixed zero-delay instance: basic write/read.
    axiWrite(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, br);
    checkOutput("write DEADBEEF bresp", br, OKAY);
    axiRead(0, 32'h8000_0010, 0, rd, rr, lat, dl);
    checkOutput("read DEADBEEF latency", lat, 2);
    checkOutput("read DEADBEEF data", rd, 32'hDEAD_BEEF);
    checkOutput("read DEADBEEF resp", rr, OKAY);

    axiWrite(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0, br);
    checkOutput("partial strobe bresp", br, OKAY);
    axiRead(0, 32'h8000_0010, 0, rd, rr, lat, dl);
    checkOutput("partial strobe data", rd, 32'hDE22_BE44);

    axiWrite(0, 32'h8000_0012, 32'hFFFF_FFFF, 4'h0, 0, 0, br);
    checkOutput("zero strobe bresp", br, OKAY);
    axiRead(0, 32'h8000_0013, 0, rd, rr, lat, dl);
    checkOutput("zero strobe data", rd, 32'hDE22_BE44);

    // Range boundaries.
    axiWrite(0, 32'h8001_FFFC, 32'hCAFE_F00D, 4'hF, 0, 0, br);
    checkOutput("last word bresp", br, OKAY);
    axiRead(0, 32'h8001_FFFC, 0, rd, rr, lat, dl);
    checkOutput("last word data", rd, 32'hCAFE_F00D);
    checkOutput("last word resp", rr, OKAY);
    axiRead(0, 32'h8002_0000, 0, rd, rr, lat, dl);
    checkOutput("oor read data", rd, 0);
    checkOutput("oor read resp", rr, DECERR);
    axiWrite(0, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, 0, br);
    checkOutput("oor low write bresp", br, DECERR);
    axiRead(0, 32'h8001_FFFC, 0, rd, rr, lat, dl);
    checkOutput("oor low write no alias", rd, 32'hCAFE_F00D);
    axiWrite(0, 32'h8002_0010, 32'h1234_5678, 4'hF, 0, 0, br);
    checkOutput("oor high write bresp", br, DECERR);
    axiRead(0, 32'h8000_0010, 0, rd, rr, lat, dl);
    checkOutput("oor high write no alias", rd, 32'hDE22_BE44);

    // Channel ordering.
    axiWrite(0, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 3, 0, br);
    checkOutput("W before AW bresp", br, OKAY);
    checkOutput("W before AW single B", bValid[0], 0);
    axiWrite(0, 32'h8000_0024, 32'h600D_CAFE, 4'hF, 0, 2, br);
    checkOutput("AW before W bresp", br, OKAY);
    axiRead(0, 32'h8000_0024, 0, rd, rr, lat, dl);
    checkOutput("AW before W data", rd, 32'h600D_CAFE);

    // R backpressure: 5 stalled cycles.
    axiRead(0, 32'h8000_0020, 5, rd, rr, lat, dl);
    checkOutput("stalled read data", rd, 32'h0BAD_F00D);
    checkOutput("ar_ready after stall", arReady[0], 1);

    // Read sampling in the commit cycle sees old data; the next read sees new.
    axiWrite(0, 32'h8000_0030, 32'h1111_1111, 4'hF, 0, 0, br);
    fork
      axiWrite(0, 32'h8000_0030, 32'h2222_2222, 4'hF, 0, 0, brX);
      axiRead(0, 32'h8000_0030, 0, rdOld, rr, latX, dlX);
    join
    checkOutput("same-cycle read old data", rdOld, 32'h1111_1111);
    checkOutput("same-cycle write bresp", brX, OKAY);
    axiRead(0, 32'h8000_0030, 0, rd, rr, lat, dl);
    checkOutput("after-commit read new data", rd, 32'h2222_2222);

    // Random-latency instance against a scoreboard.
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      axiWrite(1, BASE + 32'(i * 4), v, 4'hF, 0, 0, br);
      sb[i] = v;
      checkOutput("rnd init bresp", br, OKAY);
    end
    for (int n = 0; n < 936; n++) begin
      idx = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        axiRead(1, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), 0, rd, rr, lat, dl);
        checkOutput("rnd read data", rd, sb[idx]);
        checkOutput("rnd read latency", lat, 2 + int'(dl));
      end else begin
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        axiWrite(1, BASE + 32'(idx * 4), v, s, $urandom_range(0, 2), $urandom_range(0, 2), br);
        for (int b = 0; b < 4; b++) if (s[b]) sb[idx][8*b +: 8] = v[8*b +: 8];
        checkOutput("rnd write bresp", br, OKAY);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      arValid[d] = 1'b0; arAddr[d] = '0; rReady[d] = 1'b0;
      awValid[d] = 1'b0; awAddr[d] = '0; wValid[d] = 1'b0;
      wData[d] = '0; wStrb[d] = '0; bReady[d] = 1'b0;
    end
    rst = 1'b1;
    $display("[TB] start");
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
